// File: rtl/dbus_arbiter_if.sv
// Data-bus request/response types and the arbiter's bus bundle.
// slave = arbiter side, master = requesters plus memory side.
package dbus_arbiter_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

interface dbus_arbiter_if;
  import dbus_arbiter_pkg::*;

  dbus_req_t  req0;
  dbus_req_t  req1;
  dbus_resp_t resp0;
  dbus_resp_t resp1;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  req0, req1, dresp,
    output resp0, resp1, dreq, grant, busy, timeout_err
  );

  modport master (
    output req0, req1, dresp,
    input  resp0, resp1, dreq, grant, busy, timeout_err
  );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter (port 0 = PTW, port 1 = mem stage) with sticky watchdog.
// Define DBUS_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to port 0.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  dbus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  dbus_req_t   dreq_q, dreq_d;
  logic        last_q, last_d;
  logic [15:0] wdog_q, wdog_d;
  logic        tout_q, tout_d;
  logic        tie_pick1;
  logic        pick1;

`ifdef DBUS_ARB_RR_EN
  // On a tie the port that did not win last time goes next.
  assign tie_pick1 = ~last_q;
`else
  logic unused_last;
  assign tie_pick1   = 1'b0;
  assign unused_last = last_q;
`endif

  always_comb begin
    state_d = state_q;
    dreq_d  = dreq_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    tout_d  = tout_q;
    pick1   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0.valid || bus.req1.valid) begin
          pick1        = bus.req1.valid && (!bus.req0.valid || tie_pick1);
          dreq_d       = pick1 ? bus.req1 : bus.req0;
          dreq_d.valid = 1'b1;
          state_d      = pick1 ? BUSY1 : BUSY0;
          wdog_d       = '0;
        end
      end
      BUSY0, BUSY1: begin
        if (bus.dresp.data_ok) begin
          state_d      = IDLE;
          dreq_d.valid = 1'b0;
          last_d       = (state_q == BUSY1);
        end else begin
          if (wdog_q != '1) begin
            wdog_d = wdog_q + 16'd1;
          end
          if (wdog_d == 16'(TIMEOUT_CYCLES)) begin
            tout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dreq_q  <= '0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dreq_q  <= dreq_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      tout_q  <= tout_d;
    end
  end

  // Responses are steered combinationally so the owner sees data_ok with no added latency.
  assign bus.grant       = {state_q == BUSY1, state_q == BUSY0};
  assign bus.busy        = |bus.grant;
  assign bus.resp0       = (state_q == BUSY0) ? bus.dresp : '0;
  assign bus.resp1       = (state_q == BUSY1) ? bus.dresp : '0;
  assign bus.dreq        = dreq_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Two-requester arbiter that shares the single core data-bus port (`dbus_req_t`/`dbus_resp_t`) between the page-table walker (port 0) and the memory-stage load/store path (port 1). It sits between those requesters and the memory interface. It grants one transaction at a time and registers the granted request toward memory. It holds the grant until `data_ok`, routes the response only to the owner, and flags stalled transactions with a sticky timeout error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024, meaning: number of BUSY cycles without `data_ok` before `timeout_err` sets; legal range 1..65535.

Ports:
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `req0` input, `dbus_req_t`: page-table-walker request.
- `resp0` output, `dbus_resp_t`: response to port 0.
- `req1` input, `dbus_req_t`: memory-stage request.
- `resp1` output, `dbus_resp_t`: response to port 1.
- `dreq` output, `dbus_req_t`: request to memory.
- `dresp` input, `dbus_resp_t`: response from memory.
- `grant` output, 2 bits: one-hot owner. Bit 0 is port 0, bit 1 is port 1. `00` means idle.
- `busy` output, 1 bit: a transaction is outstanding.
- `timeout_err` output, 1 bit: sticky watchdog flag.

## Operation
- States: IDLE, BUSY0, BUSY1.
- IDLE:
  - Only `reqN.valid` is sampled.
  - If exactly one port is valid, it wins.
  - If both are valid, the winner follows the priority policy (see Configuration).
  - On the clock edge, the winner's full request (`addr`, `size`, `strobe`, `data`) is captured into the `dreq` register, `dreq.valid` is set, and the state moves to BUSYn.
- BUSYn:
  - `dreq` stays constant.
  - `respN` equals `dresp` combinationally. All fields of the other port's response are 0.
  - When `dresp.data_ok` is 1, the state moves to IDLE on the next edge, `dreq.valid` clears, and the last-grant pointer is set to n.
- Requester rule: hold `valid` and all request fields stable until your own `data_ok`. Requests from a non-granted port are ignored, not queued; that port simply keeps waiting.
- `grant` is `{state==BUSY1, state==BUSY0}`. `busy` is `|grant`.
- Watchdog:
  - A 16-bit counter clears on entry to BUSYn and increments each BUSY cycle without `data_ok`, saturating at 0xFFFF.
  - When the counter equals `TIMEOUT_CYCLES`, `timeout_err` sets and stays set until reset.
  - The transaction is not aborted.
- Reset values:
  - State is IDLE.
  - All `dreq` fields are 0.
  - `resp0` and `resp1` are 0.
  - `grant` is `00` and `busy` is 0.
  - `timeout_err` is 0, the watchdog counter is 0, and the last-grant pointer is 1, so port 0 wins the first tie.
- Reset mid-transaction: immediately forces IDLE and `dreq.valid`=0. The outstanding response is discarded. The memory side must be reset by the same signal.

## Timing
- Grant latency: a request that is valid in an IDLE cycle N produces `dreq.valid`=1 in cycle N+1.
- Response latency: zero added cycles. `respN.data_ok` is asserted in the same cycle as `dresp.data_ok`.
- Turnaround: every transaction is followed by exactly one IDLE cycle. A `data_ok` in cycle M allows the next grant edge at the end of cycle M+1 and the next `dreq.valid` in cycle M+2.
- Simultaneous new request and `data_ok`: the request is not sampled in the BUSY cycle and is arbitrated in the following IDLE cycle.
- `data_ok` while in IDLE: ignored, and both responses stay 0.
- Request deasserted by the owner before `data_ok`: this is a protocol violation, and the arbiter stays BUSY until `data_ok`.
- Minimum throughput is one transaction per 3 cycles, given one-cycle memory.

## Configuration
- `DBUS_ARB_RR_EN`:
  - Defined: round-robin. On a tie, the port that is not the last-grant pointer wins.
  - Undefined: fixed priority. Port 0 (PTW) always wins ties; the last-grant pointer is still maintained but unused.

## Test plan
- Single request: `req1` read with addr 0x8000_0010, size MSIZE8; memory returns `data_ok` 2 cycles after `dreq.valid` with data 0x1122_3344_5566_7788. Expected: `dreq` mirrors `req1` one cycle after `req1.valid` rises, `resp1.data` is 0x1122_3344_5566_7788 in the `data_ok` cycle, `resp0` stays 0, and `grant` sequence is 00→10→10→10→00.
- Tie after reset: `req0` and `req1` are both valid continuously. Expected with `DBUS_ARB_RR_EN`: grants are port 0, port 1, port 0, port 1. Expected without it: port 0 on every grant.
- Write passthrough: `req0` has strobe 0xF0, data 0xDEAD_BEEF_0000_0000, addr 0x8000_1004. Expected: `dreq.strobe`=0xF0 and the data and address are identical and stable throughout BUSY0.
- Overlapping `data_ok`: `req0` rises in the same cycle as `data_ok` for port 1. Expected: one IDLE cycle follows, then `grant`=01.
- Watchdog: `TIMEOUT_CYCLES`=4 and memory never asserts `data_ok`. Expected: `timeout_err` rises after 4 BUSY cycles and stays high. A later `data_ok` completes the transaction normally and `timeout_err` remains 1.
- Async reset during BUSY1: assert `reset` between clock edges. Expected: `dreq.valid`, `grant`, and `timeout_err` go to 0 without waiting for a clock edge, and the next tie is won by port 0.
